// File: rtl/io_port_unit_pkg.sv
// Shared defaults and sizing helpers for the I/O port unit and its input FIFO.
package io_port_unit_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_IN_DEPTH    = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // Width of a counter that must hold every value from 0 to depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/io_in_fifo.sv
// First-word-fall-through FIFO with occupancy count; push/pop arrive already qualified.
module io_in_fifo
  import io_port_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_IN_DEPTH,
  localparam int CW    = count_w(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]     count_reg;

  // Explicit wrap so non-power-of-two depths work.
  assign rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
  assign wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_next;
      if (pop)  rd_ptr_reg <= rd_ptr_next;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/io_port_unit.sv
// Processor I/O port block: input FIFO, registered output port with strobe, synchronised latched interrupt.
module io_port_unit
  import io_port_unit_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IN_DEPTH    = DEF_IN_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter bit IRQ_ON_DATA = 1'b0,
  localparam int CW         = count_w(IN_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] inputPort,
  input  logic              in_strobe,
  input  logic              in_rd_en,
  output logic [DATA_W-1:0] in_rd_data,
  output logic              in_empty,
  output logic              in_full,
  output logic [CW-1:0]     in_count,
  output logic              in_ovf,
  input  logic              ovf_clr,
  input  logic              out_wr_en,
  input  logic [DATA_W-1:0] out_wr_data,
  output logic [DATA_W-1:0] outputPort,
  output logic              out_strobe,
  input  logic              interrupt,
  input  logic              irq_en,
  output logic              irq_req,
  input  logic              irq_ack
);

  logic push, pop, ovf_set;

  // A pop in the same cycle frees the slot, so a strobe into a full FIFO is accepted then.
  assign push    = in_strobe & start & (~in_full | in_rd_en);
  assign pop     = in_rd_en & ~in_empty;
  assign ovf_set = in_strobe & start & in_full & ~in_rd_en;

  io_in_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (IN_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (inputPort),
    .rd_data (in_rd_data),
    .empty   (in_empty),
    .full    (in_full),
    .count   (in_count)
  );

  logic ovf_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          ovf_reg <= 1'b0;
    else if (ovf_set)  ovf_reg <= 1'b1;
    else if (ovf_clr)  ovf_reg <= 1'b0;
  end

  assign in_ovf = ovf_reg;

  logic [DATA_W-1:0] out_port_reg;
  logic              out_strobe_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_port_reg   <= '0;
      out_strobe_reg <= 1'b0;
    end else begin
      if (out_wr_en) out_port_reg <= out_wr_data;
      out_strobe_reg <= out_wr_en;
    end
  end

  assign outputPort = out_port_reg;
  assign out_strobe = out_strobe_reg;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_prev_reg;
  logic                   pin_rise;
  logic                   pending_reg, pending_next;
  logic                   irq_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg      <= '0;
      sync_prev_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], interrupt};
      sync_prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign pin_rise = sync_reg[SYNC_STAGES-1] & ~sync_prev_reg;
  assign irq_set  = start & ((irq_en & pin_rise) | (IRQ_ON_DATA & push & in_empty));

  // A new request outranks an acknowledge arriving in the same cycle.
  always_comb begin
    pending_next = pending_reg;
    if (irq_set)      pending_next = 1'b1;
    else if (irq_ack) pending_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_reg <= 1'b0;
    else      pending_reg <= pending_next;
  end

  assign irq_req = pending_reg;

endmodule

// File: tb/tb_io_port_unit.sv
// Directed self-checking bench for io_port_unit with default parameters (16-bit, depth 4, 2 sync stages).
module tb_io_port_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] inputPort;
  logic        in_strobe;
  logic        in_rd_en;
  logic [15:0] in_rd_data;
  logic        in_empty;
  logic        in_full;
  logic [2:0]  in_count;
  logic        in_ovf;
  logic        ovf_clr;
  logic        out_wr_en;
  logic [15:0] out_wr_data;
  logic [15:0] outputPort;
  logic        out_strobe;
  logic        interrupt;
  logic        irq_en;
  logic        irq_req;
  logic        irq_ack;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  io_port_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .inputPort   (inputPort),
    .in_strobe   (in_strobe),
    .in_rd_en    (in_rd_en),
    .in_rd_data  (in_rd_data),
    .in_empty    (in_empty),
    .in_full     (in_full),
    .in_count    (in_count),
    .in_ovf      (in_ovf),
    .ovf_clr     (ovf_clr),
    .out_wr_en   (out_wr_en),
    .out_wr_data (out_wr_data),
    .outputPort  (outputPort),
    .out_strobe  (out_strobe),
    .interrupt   (interrupt),
    .irq_en      (irq_en),
    .irq_req     (irq_req),
    .irq_ack     (irq_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-18s got=%0h", tag, got);
    end else begin
      $display("FAIL %-18s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic strobe_word(input logic [15:0] w);
    inputPort = w;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] exp);
    check(tag, in_rd_data, exp);
    in_rd_en = 1'b1;
    tick();
    in_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; inputPort = '0; in_strobe = 1'b0; in_rd_en = 1'b0;
    ovf_clr = 1'b0; out_wr_en = 1'b0; out_wr_data = '0; interrupt = 1'b0;
    irq_en = 1'b0; irq_ack = 1'b0;
    tick(2);
    rst = 1'b1;
    start = 1'b1;

    // 1: reset state, three words in and out in order
    check("rst_count", in_count, 0);
    check("rst_empty", in_empty, 1);
    check("rst_rd_data", in_rd_data, 0);
    check("rst_outport", outputPort, 0);
    check("rst_irq", irq_req, 0);
    strobe_word(16'h0019);
    check("first_head", in_rd_data, 16'h0019);
    strobe_word(16'h000F);
    strobe_word(16'hF320);
    check("count3", in_count, 3);
    pop_expect("pop1", 16'h0019);
    pop_expect("pop2", 16'h000F);
    pop_expect("pop3", 16'hF320);
    check("drained_empty", in_empty, 1);
    check("drained_data", in_rd_data, 0);
    in_rd_en = 1'b1; tick(); in_rd_en = 1'b0;
    check("pop_on_empty", in_count, 0);

    // 2: fill past depth, overflow is sticky and clearable
    strobe_word(16'h1111);
    strobe_word(16'h2222);
    strobe_word(16'h3333);
    check("not_full3", in_full, 0);
    strobe_word(16'h4444);
    check("full", in_full, 1);
    check("no_ovf_yet", in_ovf, 0);
    strobe_word(16'h5555);
    check("ovf_set", in_ovf, 1);
    check("count_full", in_count, 4);
    inputPort = 16'h5A5A; in_strobe = 1'b1; ovf_clr = 1'b1;
    tick();
    in_strobe = 1'b0;
    check("ovf_beats_clr", in_ovf, 1);
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", in_ovf, 0);

    // 3: push+pop while full, pointers wrap
    check("head_full", in_rd_data, 16'h1111);
    inputPort = 16'h6666; in_strobe = 1'b1; in_rd_en = 1'b1;
    tick();
    in_strobe = 1'b0; in_rd_en = 1'b0;
    check("pp_count", in_count, 4);
    check("pp_ovf", in_ovf, 0);
    pop_expect("wrap_pop1", 16'h2222);
    pop_expect("wrap_pop2", 16'h3333);
    pop_expect("wrap_pop3", 16'h4444);
    pop_expect("wrap_pop4", 16'h6666);
    check("wrap_empty", in_empty, 1);

    // 4: back-to-back OUT writes
    out_wr_en = 1'b1; out_wr_data = 16'hABCD;
    tick();
    check("out1_port", outputPort, 16'hABCD);
    check("out1_strobe", out_strobe, 1);
    out_wr_data = 16'h1234;
    tick();
    out_wr_en = 1'b0;
    check("out2_port", outputPort, 16'h1234);
    check("out2_strobe", out_strobe, 1);
    tick();
    check("out_idle_port", outputPort, 16'h1234);
    check("out_idle_strobe", out_strobe, 0);

    // 5: pin to request latency, ack, edge during ack cycle
    irq_en = 1'b1;
    interrupt = 1'b1;
    tick(2);
    check("irq_lat2", irq_req, 0);
    tick();
    check("irq_lat3", irq_req, 1);
    interrupt = 1'b0;
    tick(3);
    interrupt = 1'b1;
    tick(2);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("set_beats_ack", irq_req, 1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("ack_clears", irq_req, 0);

    // 6: reset mid-operation, then start=0 blocks pushes and interrupt
    interrupt = 1'b0;
    tick(3);
    interrupt = 1'b1;
    strobe_word(16'hAAAA);
    strobe_word(16'hBBBB);
    tick();
    check("pre_rst_count", in_count, 2);
    check("pre_rst_irq", irq_req, 1);
    out_wr_en = 1'b1; out_wr_data = 16'h7777;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    out_wr_en = 1'b0;
    check("arst_count", in_count, 0);
    check("arst_empty", in_empty, 1);
    check("arst_rd_data", in_rd_data, 0);
    check("arst_irq", irq_req, 0);
    check("arst_outport", outputPort, 0);
    check("arst_strobe", out_strobe, 0);
    tick(2);
    start = 1'b0;
    rst = 1'b1;
    strobe_word(16'hCCCC);
    tick(4);
    check("nostart_count", in_count, 0);
    check("nostart_irq", irq_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
